part3: RTL and testbench



---
 rtl/part3.sv | 109 ++++++++++
 tb/tb_part3.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/part3.sv
// Streaming running-L2-norm: saturating sum of squares followed by a
// 10-stage restoring integer square root, one result per accepted sample.
module part3 #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OUT_W  = 10,
    parameter int unsigned ACC_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] a,
    input  logic              valid_in,
    output logic [OUT_W-1:0]  g,
    output logic              valid_out
);

    localparam int unsigned RW = OUT_W + 3;

    logic [DATA_W-1:0]   r_a;
    logic                r_v0;
    logic [ACC_W-1:0]    r_acc;
    logic                r_v1;
    logic [OUT_W-1:0]    r_g;
    logic                r_vout;

    logic [ACC_W-1:0]    r_x    [OUT_W-1];
    logic [RW-1:0]       r_rem  [OUT_W-1];
    logic [OUT_W-1:0]    r_root [OUT_W-1];
    logic                r_sv   [OUT_W-1];

    logic [2*DATA_W-1:0] w_sq;
    logic [ACC_W:0]      w_sum;
    logic [ACC_W-1:0]    w_acc_nx;

    logic [ACC_W-1:0]    w_x_in    [OUT_W];
    logic [RW-1:0]       w_rem_in  [OUT_W];
    logic [OUT_W-1:0]    w_root_in [OUT_W];
    logic                w_v_in    [OUT_W];
    logic [RW-1:0]       w_cat     [OUT_W];
    logic [RW-1:0]       w_trial   [OUT_W];
    logic [RW-1:0]       w_rem_nx  [OUT_W];
    logic [OUT_W-1:0]    w_root_nx [OUT_W];

    assign w_sq     = r_a * r_a;
    assign w_sum    = {1'b0, r_acc} + {{(ACC_W + 1 - 2 * DATA_W){1'b0}}, w_sq};
    assign w_acc_nx = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

    // Each stage consumes the top two radicand bits; x is pre-shifted between stages.
    always_comb begin
        w_x_in[0]    = r_acc;
        w_rem_in[0]  = '0;
        w_root_in[0] = '0;
        w_v_in[0]    = r_v1;
        for (int s = 1; s < OUT_W; s++) begin
            w_x_in[s]    = r_x[s-1];
            w_rem_in[s]  = r_rem[s-1];
            w_root_in[s] = r_root[s-1];
            w_v_in[s]    = r_sv[s-1];
        end
        for (int s = 0; s < OUT_W; s++) begin
            w_cat[s]   = {w_rem_in[s][RW-3:0], w_x_in[s][ACC_W-1 -: 2]};
            w_trial[s] = {1'b0, w_root_in[s], 2'b01};
            if (w_cat[s] >= w_trial[s]) begin
                w_rem_nx[s]  = w_cat[s] - w_trial[s];
                w_root_nx[s] = {w_root_in[s][OUT_W-2:0], 1'b1};
            end else begin
                w_rem_nx[s]  = w_cat[s];
                w_root_nx[s] = {w_root_in[s][OUT_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_v0   <= 1'b0;
            r_acc  <= '0;
            r_v1   <= 1'b0;
            r_g    <= '0;
            r_vout <= 1'b0;
            for (int s = 0; s < OUT_W - 1; s++) begin
                r_x[s]    <= '0;
                r_rem[s]  <= '0;
                r_root[s] <= '0;
                r_sv[s]   <= 1'b0;
            end
        end else begin
            r_a  <= a;
            r_v0 <= valid_in;
            r_v1 <= r_v0;
            if (r_v0) begin
                r_acc <= w_acc_nx;
            end
            for (int s = 0; s < OUT_W - 1; s++) begin
                r_x[s]    <= w_x_in[s] << 2;
                r_rem[s]  <= w_rem_nx[s];
                r_root[s] <= w_root_nx[s];
                r_sv[s]   <= w_v_in[s];
            end
            r_vout <= w_v_in[OUT_W-1];
            if (w_v_in[OUT_W-1]) begin
                r_g <= w_root_nx[OUT_W-1];
            end
        end
    end

    assign g         = r_g;
    assign valid_out = r_vout;

endmodule

// File: tb/tb_part3.sv
// Self-checking bench for part3: cycle-level reference model of the running
// saturating L2 norm plus directed literal checks and a random stream.
module tb_part3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] a = 8'd0;
    logic [9:0] g;
    logic       valid_out;

    always #5 clk = ~clk;

    part3 dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .valid_in (valid_in),
        .g        (g),
        .valid_out(valid_out)
    );

    int checks = 0;
    int errors = 0;
    int got[$];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic int at(input int i);
        if (got.size() > i) return got[i];
        return -1;
    endfunction

    // Reference: sample accepted at edge N appears after edge N+11.
    int m_acc = 0;
    bit m_v[11];
    int m_g[11];
    int m_hold = 0;
    bit m_ov;
    int m_og;
    bit s_r, s_v;
    int s_a;

    always @(posedge clk) begin
        s_r = reset;
        s_v = valid_in;
        s_a = int'(a);
        m_ov = 1'b0;
        if (s_r) begin
            m_acc = 0;
            m_hold = 0;
            for (int i = 0; i < 11; i++) m_v[i] = 1'b0;
        end else begin
            m_ov = m_v[10];
            m_og = m_g[10];
            for (int i = 10; i > 0; i--) begin
                m_v[i] = m_v[i-1];
                m_g[i] = m_g[i-1];
            end
            m_v[0] = s_v;
            m_g[0] = 0;
            if (s_v) begin
                m_acc = m_acc + s_a * s_a;
                if (m_acc > 1048575) m_acc = 1048575;
                m_g[0] = isqrt(m_acc);
            end
            if (m_ov) m_hold = m_og;
        end
        #1;
        chk("valid_out", 32'(valid_out), int'(m_ov));
        chk("g", 32'(g), m_hold);
        if (valid_out === 1'b1) got.push_back(int'(g));
    end

    task automatic drive(input bit v, input int av);
        @(negedge clk);
        reset = 1'b0;
        valid_in = v;
        a = 8'(av);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        valid_in = 1'b0;
        got.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_vout", 32'(valid_out), 0);
        chk("rst_g", 32'(g), 0);

        // Back-to-back samples
        got.delete();
        drive(1'b1, 3);
        drive(1'b1, 4);
        idle(14);
        chk("t1_n", 32'(got.size()), 2);
        chk("t1_0", 32'(at(0)), 3);
        chk("t1_1", 32'(at(1)), 5);

        // Valid gaps
        do_reset();
        drive(1'b1, 5);
        idle(1);
        drive(1'b1, 12);
        idle(2);
        drive(1'b1, 0);
        idle(14);
        chk("t2_n", 32'(got.size()), 3);
        chk("t2_0", 32'(at(0)), 5);
        chk("t2_1", 32'(at(1)), 13);
        chk("t2_2", 32'(at(2)), 13);

        // Reset mid-stream discards in-flight samples
        do_reset();
        drive(1'b1, 9);
        drive(1'b1, 9);
        drive(1'b1, 9);
        do_reset();
        idle(14);
        chk("t3_drain_n", 32'(got.size()), 0);
        chk("t3_drain_g", 32'(g), 0);
        drive(1'b1, 6);
        idle(14);
        chk("t3_n", 32'(got.size()), 1);
        chk("t3_0", 32'(at(0)), 6);

        // Saturation
        do_reset();
        repeat (16) drive(1'b1, 255);
        idle(14);
        chk("t4_n16", 32'(got.size()), 16);
        chk("t4_16", 32'(at(15)), 1020);
        drive(1'b1, 255);
        idle(14);
        chk("t4_17", 32'(at(16)), 1023);
        drive(1'b1, 255);
        drive(1'b1, 0);
        idle(14);
        chk("t4_18", 32'(at(17)), 1023);
        chk("t4_19", 32'(at(18)), 1023);

        // Zero and small boundary values
        do_reset();
        drive(1'b1, 0);
        repeat (4) drive(1'b1, 1);
        idle(14);
        chk("t5_n", 32'(got.size()), 5);
        chk("t5_0", 32'(at(0)), 0);
        chk("t5_1", 32'(at(1)), 1);
        chk("t5_2", 32'(at(2)), 1);
        chk("t5_3", 32'(at(3)), 1);
        chk("t5_4", 32'(at(4)), 2);

        // Random stream with occasional resets
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                @(negedge clk);
                reset = 1'b1;
                valid_in = 1'($urandom_range(0, 1));
                a = 8'($urandom_range(0, 255));
            end else begin
                drive($urandom_range(0, 9) < 6,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                  : int'($urandom_range(0, 40)));
            end
        end
        idle(14);
        chk("rand_outputs_seen", 32'(got.size() > 100), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
